tmds_decoder_dvi_align: RTL and testbench



---
 rtl/tmds_decoder_dvi_align.sv | 244 ++++++++++++++++++++++++
 tb/tb_tmds_decoder_dvi_align.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tmds_decoder_dvi_align.sv
// -----------------------------------------------------------------------------
// tmds_decoder_dvi_align
//
// Receive-side TMDS channel decoder for DVI. It takes unaligned 10-bit words
// from a 1:10 deserializer and finds the TMDS word boundary using the DVI
// control tokens. It tracks alignment lock and decodes each aligned word into
// pixel data, a control value and display enable. There is one instance per
// channel; the parent combines the lock flags of the channels.
//
// Parameters
//   TOKEN_TIMEOUT  cycles without a control token before the block advances the
//                  bit offset (while searching) or drops lock (while locked).
//                  It must exceed the longest active-video run. Minimum 4.
//   LOCK_TOKENS    consecutive control tokens needed to declare lock (2..255)
//
// Ports
//   i_pix_clk  in   1   pixel clock; all logic runs on the rising edge
//   i_rst_n    in   1   asynchronous active-low reset
//   i_tmds     in  10   raw deserializer word; bit 0 is the earliest bit
//   o_data     out  8   decoded pixel data
//   o_ctrl     out  2   last decoded control value {c1,c0}
//   o_de       out  1   display enable; high for a data word while locked
//   o_locked   out  1   word alignment locked
//   o_offset   out  4   current bit offset, 0..9
// -----------------------------------------------------------------------------
module tmds_decoder_dvi_align #(
    parameter int TOKEN_TIMEOUT = 4096,
    parameter int LOCK_TOKENS   = 16
) (
    input  logic       i_pix_clk,
    input  logic       i_rst_n,
    input  logic [9:0] i_tmds,
    output logic [7:0] o_data,
    output logic [1:0] o_ctrl,
    output logic       o_de,
    output logic       o_locked,
    output logic [3:0] o_offset
);

    localparam int TIMER_W = (TOKEN_TIMEOUT > 2) ? $clog2(TOKEN_TIMEOUT) : 2;
    localparam int RUN_W   = 8;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TOKEN_TIMEOUT - 1);
    localparam logic [RUN_W-1:0]   RUN_LOCK   = RUN_W'(LOCK_TOKENS);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Word classification and TMDS data decode
    // -------------------------------------------------------------------------
    function automatic logic is_token(input logic [9:0] w);
        return (w == 10'b1101010100) || (w == 10'b0010101011) ||
               (w == 10'b0101010100) || (w == 10'b1010101011);
    endfunction

    function automatic logic [1:0] token_ctrl(input logic [9:0] w);
        logic [1:0] c;
        case (w)
            10'b0010101011: c = 2'b01;
            10'b0101010100: c = 2'b10;
            10'b1010101011: c = 2'b11;
            default:        c = 2'b00;
        endcase
        return c;
    endfunction

    // bit 9 selects inversion of the payload, bit 8 selects XOR vs XNOR chaining
    function automatic logic [7:0] decode_data(input logic [9:0] w);
        logic [7:0] q;
        logic [7:0] d;
        q    = w[9] ? ~w[7:0] : w[7:0];
        d    = '0;
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

    // -------------------------------------------------------------------------
    // Signals
    // -------------------------------------------------------------------------
    logic [9:0]         prev_p0;
    logic [18:0]        window_c;
    logic [9:0]         window_sel;
    logic [9:0]         aligned_p1;
    logic               tok_p1;

    logic [7:0]         data_p2;
    logic [1:0]         ctrl_p2;
    logic               de_p2;
    logic               locked_p2;

    state_t             state_q, state_d;
    logic [3:0]         offset_q, offset_d;
    logic [3:0]         offset_inc;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [RUN_W-1:0]   run_inc;
    logic               skip_q, skip_d;

    // -------------------------------------------------------------------------
    // Stage 0 -> 1: two-word window and bit-offset selection
    // -------------------------------------------------------------------------
    // window_c[j] is the j-th bit in time across the previous and current word.
    // Offsets only reach 9, so the top bit of the current word is never needed.
    assign window_c = {i_tmds[8:0], prev_p0};

    always_comb begin
        window_sel = window_c[9:0];
        case (offset_q)
            4'd1:    window_sel = window_c[10:1];
            4'd2:    window_sel = window_c[11:2];
            4'd3:    window_sel = window_c[12:3];
            4'd4:    window_sel = window_c[13:4];
            4'd5:    window_sel = window_c[14:5];
            4'd6:    window_sel = window_c[15:6];
            4'd7:    window_sel = window_c[16:7];
            4'd8:    window_sel = window_c[17:8];
            4'd9:    window_sel = window_c[18:9];
            default: window_sel = window_c[9:0];
        endcase
    end

    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prev_p0    <= '0;
            aligned_p1 <= '0;
        end else begin
            prev_p0    <= i_tmds;
            aligned_p1 <= window_sel;
        end
    end

    assign tok_p1 = is_token(aligned_p1);

    // -------------------------------------------------------------------------
    // Stage 1 -> 2: decode of the aligned word
    // -------------------------------------------------------------------------
    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_p2 <= '0;
            ctrl_p2 <= '0;
            de_p2   <= 1'b0;
        end else if (tok_p1) begin
            data_p2 <= '0;
            ctrl_p2 <= token_ctrl(aligned_p1);
            de_p2   <= 1'b0;
        end else begin
            // control value is sticky across data words
            data_p2 <= locked_p2 ? decode_data(aligned_p1) : 8'd0;
            de_p2   <= locked_p2;
        end
    end

    // -------------------------------------------------------------------------
    // Alignment FSM, evaluated on the stage-1 word
    // -------------------------------------------------------------------------
    assign offset_inc = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
    assign run_inc    = run_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        timer_d  = timer_q;
        run_d    = run_q;
        skip_d   = 1'b0;

        // The word right after an offset change was cut with the old offset,
        // so it carries no information about the new alignment.
        if (!skip_q) begin
            case (state_q)
                ST_SEARCH: begin
                    if (tok_p1) begin
                        state_d = ST_CHECK;
                        run_d   = 8'd1;
                    end else if (timer_q == TIMER_LAST) begin
                        offset_d = offset_inc;
                        timer_d  = '0;
                        skip_d   = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (tok_p1) begin
                        run_d = run_inc;
                        if (run_inc == RUN_LOCK) begin
                            state_d = ST_LOCKED;
                            timer_d = '0;
                        end
                    end else begin
                        state_d = ST_SEARCH;
                        timer_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (tok_p1) begin
                        timer_d = '0;
                    end else if (timer_q == TIMER_LAST) begin
                        state_d  = ST_SEARCH;
                        offset_d = offset_inc;
                        timer_d  = '0;
                        skip_d   = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_pix_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_SEARCH;
            offset_q  <= '0;
            timer_q   <= '0;
            run_q     <= '0;
            skip_q    <= 1'b0;
            locked_p2 <= 1'b0;
        end else begin
            state_q   <= state_d;
            offset_q  <= offset_d;
            timer_q   <= timer_d;
            run_q     <= run_d;
            skip_q    <= skip_d;
            locked_p2 <= (state_q == ST_LOCKED);
        end
    end

    assign o_data   = data_p2;
    assign o_ctrl   = ctrl_p2;
    assign o_de     = de_p2;
    assign o_locked = locked_p2;
    assign o_offset = offset_q;

endmodule

// File: tb/tb_tmds_decoder_dvi_align.sv
// -----------------------------------------------------------------------------
// tb_tmds_decoder_dvi_align
//
// Directed bench for tmds_decoder_dvi_align with TOKEN_TIMEOUT=64 and
// LOCK_TOKENS=16. Outputs are sampled 1 ns after each rising edge and inputs
// are changed right after sampling, so they apply to the following edge.
//
// Edge numbering: edge 1 is the first rising edge after reset release.
//   - offset 0: stage-1 word equals the previous input word, so a token driven
//     from release is first seen by the FSM at edge 3 (CHECK, run=1), the FSM
//     reaches LOCKED at edge 18 (run=16), and o_locked rises at edge 19.
//   - searching: timer counts one per edge from edge 1; offset advances at edge
//     64, then every 65 edges (64 counts + one skipped word): 64, 129, 194.
//   - after the change to the right offset at edge E: skip at E+1, CHECK at
//     E+2, LOCKED at E+17, o_locked at E+18 (212 for boundary at bit 3).
// -----------------------------------------------------------------------------
module tb_tmds_decoder_dvi_align;

    localparam logic [9:0] TOK00 = 10'h354;   // 1101010100, ctrl 00

    logic       clk;
    logic       rst_n;
    logic [9:0] tmds;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
    logic       locked;
    logic [3:0] offset;

    int checks   = 0;
    int failures = 0;

    tmds_decoder_dvi_align #(
        .TOKEN_TIMEOUT (64),
        .LOCK_TOKENS   (16)
    ) dut (
        .i_pix_clk (clk),
        .i_rst_n   (rst_n),
        .i_tmds    (tmds),
        .o_data    (data),
        .o_ctrl    (ctrl),
        .o_de      (de),
        .o_locked  (locked),
        .o_offset  (offset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Deserializer word for a repeating token stream whose word boundary sits
    // at window bit k: word[j] holds token bit (j - k) mod 10.
    function automatic logic [9:0] rot_word(input logic [9:0] tok, input int k);
        logic [9:0] t;
        logic [9:0] w;
        t = tok;
        for (int j = 0; j < 10; j++) begin
            w[j] = t[(j - k + 10) % 10];
        end
        return w;
    endfunction

    task automatic wait_lock(input int limit, output int n);
        n = 0;
        while (!locked && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int         n;
        int         step_idx;
        int         step_edge [3];
        logic [3:0] last_off;

        rst_n = 1'b0;
        tmds  = '0;

        // ---------------- reset with random input ----------------
        for (int i = 0; i < 6; i++) begin
            tmds = 10'($urandom);
            tick();
            check("reset_outs", {data, ctrl, de, locked, offset}, 16'h0000);
        end

        // ---------------- aligned lock ----------------
        rst_n = 1'b1;
        tmds  = TOK00;
        wait_lock(40, n);
        check("aligned_lock_edge", n, 19);
        check("aligned_offset", offset, 0);
        check("aligned_ctrl", ctrl, 2'b00);
        check("aligned_de", de, 1'b0);

        // ---------------- decode after lock ----------------
        tmds = 10'h100;
        tick();
        tmds = 10'h200;
        tick();
        tmds = 10'h2AB;
        tick();
        check("dec_100_de", de, 1'b1);
        check("dec_100_data", data, 8'h00);
        tmds = TOK00;
        tick();
        check("dec_200_de", de, 1'b1);
        check("dec_200_data", data, 8'hFF);
        tick();
        check("dec_2ab_de", de, 1'b0);
        check("dec_2ab_ctrl", ctrl, 2'b11);
        check("dec_2ab_data", data, 8'h00);
        tick();
        check("dec_back_ctrl", ctrl, 2'b00);
        check("dec_still_locked", locked, 1'b1);

        // ---------------- misaligned: boundary at bit 3 ----------------
        rst_n = 1'b0;
        tick();
        check("rst2_outs", {data, ctrl, de, locked, offset}, 16'h0000);
        rst_n        = 1'b1;
        tmds         = rot_word(TOK00, 3);   // 10'h2A6
        n            = 0;
        step_idx     = 0;
        step_edge[0] = 0;
        step_edge[1] = 0;
        step_edge[2] = 0;
        last_off     = offset;
        while (!locked && n < 400) begin
            tick();
            n++;
            if (offset !== last_off) begin
                check("offset_step", offset, last_off + 4'd1);
                if (step_idx < 3) step_edge[step_idx] = n;
                step_idx++;
                last_off = offset;
            end
        end
        check("step1_edge", step_edge[0], 64);
        check("step2_edge", step_edge[1], 129);
        check("step3_edge", step_edge[2], 194);
        check("mis_lock_edge", n, 212);
        check("mis_offset", offset, 3);
        check("mis_ctrl", ctrl, 2'b00);

        // ---------------- lock loss ----------------
        // 0x100 cut at offset 3 gives word 0x020, which decodes to 0x9E.
        tmds = 10'h100;
        n    = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n++;
        end
        check("loss_de_before", de, 1'b1);
        check("loss_data_before", data, 8'h9E);
        while (locked && n < 200) begin
            tick();
            n++;
        end
        check("loss_drop_edge", n, 66);
        check("loss_offset", offset, 4);
        tick();
        check("loss_de_after", de, 1'b0);
        check("loss_data_after", data, 8'h00);

        // ---------------- relock at the new offset ----------------
        tmds = rot_word(TOK00, 4);
        wait_lock(60, n);
        check("relock_edge", n, 19);
        check("relock_offset", offset, 4);
        check("relock_ctrl", ctrl, 2'b00);

        // ---------------- async reset mid-lock ----------------
        #2;
        rst_n = 1'b0;
        #1;
        check("async_locked", locked, 1'b0);
        check("async_offset", offset, 0);
        check("async_outs", {data, ctrl, de}, 11'h000);
        tick();
        rst_n = 1'b1;
        tmds  = TOK00;
        wait_lock(40, n);
        check("post_rst_lock_edge", n, 19);
        check("post_rst_offset", offset, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
